// File: rtl/cpu_alu_pkg.sv
// Shared types and opcode constants for the chunk-serial adder/subtractor.
package cpu_alu_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/chunk_adder.sv
// Combinational WIDTH-bit ripple-carry adder slice used once per RUN cycle.
module chunk_adder #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);

    logic c;

    always_comb begin
        c     = carry_i;
        sum_o = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ c;
            c        = (a_i[i] & b_i[i]) | (a_i[i] & c) | (b_i[i] & c);
        end
        carry_o = c;
    end

endmodule

// File: rtl/multicycle_add_sub.sv
// Chunk-serial adder/subtractor with valid/ready handshakes on both sides.
// Define FLAGS_EN to add the zero_o/neg_o/ovf_o status outputs.
module multicycle_add_sub
    import cpu_alu_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CHUNK_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              sub_i,
    input  logic              carry_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] sum_o,
    output logic              carry_o
`ifdef FLAGS_EN
    ,
    output logic              zero_o,
    output logic              neg_o,
    output logic              ovf_o
`endif
);

    localparam int unsigned NCHUNK = DATA_W / CHUNK_W;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if ((DATA_W % CHUNK_W) != 0) begin : g_bad_cfg
        $error("multicycle_add_sub: DATA_W must be a multiple of CHUNK_W");
    end

    state_e             state_q;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    logic [DATA_W-1:0]  acc_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;

    logic [31:0]        base;
    logic [CHUNK_W-1:0] a_chunk;
    logic [CHUNK_W-1:0] b_chunk;
    logic [CHUNK_W-1:0] c_sum;
    logic               c_out;
    logic               last_chunk;
    logic [DATA_W-1:0]  acc_next;

    always_comb begin
        base       = 32'(idx_q) * CHUNK_W;
        a_chunk    = a_q[base +: CHUNK_W];
        b_chunk    = b_q[base +: CHUNK_W];
        last_chunk = (idx_q == IDX_W'(NCHUNK - 1));
        acc_next   = acc_q;
        acc_next[base +: CHUNK_W] = c_sum;
    end

    chunk_adder #(
        .WIDTH(CHUNK_W)
    ) u_chunk_adder (
        .a_i    (a_chunk),
        .b_i    (b_chunk),
        .carry_i(carry_q),
        .sum_o  (c_sum),
        .carry_o(c_out)
    );

`ifdef FLAGS_EN
    // Carry into the MSB is recovered from the MSB sum bit of the final chunk.
    logic ovf_next;
    always_comb ovf_next = a_chunk[CHUNK_W-1] ^ b_chunk[CHUNK_W-1] ^ c_sum[CHUNK_W-1] ^ c_out;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            ready_o <= 1'b1;
            valid_o <= 1'b0;
            sum_o   <= '0;
            carry_o <= 1'b0;
`ifdef FLAGS_EN
            zero_o  <= 1'b0;
            neg_o   <= 1'b0;
            ovf_o   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (valid_i && ready_o) begin
                        a_q     <= a_i;
                        b_q     <= (sub_i == OP_SUB) ? ~b_i : b_i;
                        carry_q <= (sub_i == OP_SUB) ? 1'b1 : carry_i;
                        acc_q   <= '0;
                        idx_q   <= '0;
                        ready_o <= 1'b0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    acc_q   <= acc_next;
                    carry_q <= c_out;
                    if (last_chunk) begin
                        idx_q   <= '0;
                        sum_o   <= acc_next;
                        carry_o <= c_out;
                        valid_o <= 1'b1;
`ifdef FLAGS_EN
                        zero_o  <= (acc_next == '0);
                        neg_o   <= acc_next[DATA_W-1];
                        ovf_o   <= ovf_next;
`endif
                        state_q <= StDone;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                StDone: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    ready_o <= 1'b1;
                    valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_add_sub.sv
// Directed self-checking bench: 8/4 instance for most scenarios, 8/8 instance for single-chunk latency.
module tb_multicycle_add_sub;

    logic       clk;
    logic       rst_n;
    logic       valid_i, ready_o, sub_i, carry_i, valid_o, ready_i, carry_o;
    logic [7:0] a_i, b_i, sum_o;
    logic       valid_i1, ready_o1, sub_i1, carry_i1, valid_o1, ready_i1, carry_o1;
    logic [7:0] a_i1, b_i1, sum_o1;
`ifdef FLAGS_EN
    logic       zero_o, neg_o, ovf_o, zero_o1, neg_o1, ovf_o1;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    multicycle_add_sub #(.DATA_W(8), .CHUNK_W(4)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .a_i(a_i), .b_i(b_i), .sub_i(sub_i), .carry_i(carry_i),
        .valid_o(valid_o), .ready_i(ready_i), .sum_o(sum_o), .carry_o(carry_o)
`ifdef FLAGS_EN
        , .zero_o(zero_o), .neg_o(neg_o), .ovf_o(ovf_o)
`endif
    );

    multicycle_add_sub #(.DATA_W(8), .CHUNK_W(8)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i1), .ready_o(ready_o1),
        .a_i(a_i1), .b_i(b_i1), .sub_i(sub_i1), .carry_i(carry_i1),
        .valid_o(valid_o1), .ready_i(ready_i1), .sum_o(sum_o1), .carry_o(carry_o1)
`ifdef FLAGS_EN
        , .zero_o(zero_o1), .neg_o(neg_o1), .ovf_o(ovf_o1)
`endif
    );

    // Presents one operation for a single edge; returns #1 after the accepting edge.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic sub,
                            input logic cin);
        a_i = a; b_i = b; sub_i = sub; carry_i = cin; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        while (!valid_o && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic release_result();
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_cmp++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready_o); end
        n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_o); end
        n_cmp++; if (sum_o !== 8'h00) begin n_fail++; $display("FAIL reset_sum got %h want 00", sum_o); end
        n_cmp++; if (carry_o !== 1'b0) begin n_fail++; $display("FAIL reset_carry got %b want 0", carry_o); end
        n_cmp++; if (ready_o1 !== 1'b1) begin n_fail++; $display("FAIL reset_ready1 got %b want 1", ready_o1); end
    endtask

    task automatic test_add();
        int e;
        start_op(8'h3C, 8'h58, 1'b0, 1'b1);
        n_cmp++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL add_busy_ready got %b want 0", ready_o); end
        wait_valid(e);
        n_cmp++; if (e !== 2) begin n_fail++; $display("FAIL add_latency got %0d want 2", e); end
        n_cmp++; if (sum_o !== 8'h95) begin n_fail++; $display("FAIL add_sum got %h want 95", sum_o); end
        n_cmp++; if (carry_o !== 1'b0) begin n_fail++; $display("FAIL add_carry got %b want 0", carry_o); end
`ifdef FLAGS_EN
        n_cmp++; if (ovf_o !== 1'b1) begin n_fail++; $display("FAIL add_ovf got %b want 1", ovf_o); end
        n_cmp++; if (neg_o !== 1'b1) begin n_fail++; $display("FAIL add_neg got %b want 1", neg_o); end
        n_cmp++; if (zero_o !== 1'b0) begin n_fail++; $display("FAIL add_zero got %b want 0", zero_o); end
`endif
        release_result();
        n_cmp++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL add_ready_after got %b want 1", ready_o); end
        n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL add_valid_after got %b want 0", valid_o); end
        n_cmp++; if (sum_o !== 8'h95) begin n_fail++; $display("FAIL add_sum_hold got %h want 95", sum_o); end
    endtask

    task automatic test_sub();
        int e;
        // carry_i=1 must be ignored on subtract.
        start_op(8'h10, 8'h20, 1'b1, 1'b1);
        wait_valid(e);
        n_cmp++; if (e !== 2) begin n_fail++; $display("FAIL sub1_latency got %0d want 2", e); end
        n_cmp++; if (sum_o !== 8'hF0) begin n_fail++; $display("FAIL sub1_sum got %h want f0", sum_o); end
        n_cmp++; if (carry_o !== 1'b0) begin n_fail++; $display("FAIL sub1_carry got %b want 0", carry_o); end
`ifdef FLAGS_EN
        n_cmp++; if (neg_o !== 1'b1) begin n_fail++; $display("FAIL sub1_neg got %b want 1", neg_o); end
        n_cmp++; if (ovf_o !== 1'b0) begin n_fail++; $display("FAIL sub1_ovf got %b want 0", ovf_o); end
`endif
        release_result();
        start_op(8'h20, 8'h20, 1'b1, 1'b0);
        wait_valid(e);
        n_cmp++; if (sum_o !== 8'h00) begin n_fail++; $display("FAIL sub2_sum got %h want 00", sum_o); end
        n_cmp++; if (carry_o !== 1'b1) begin n_fail++; $display("FAIL sub2_carry got %b want 1", carry_o); end
`ifdef FLAGS_EN
        n_cmp++; if (zero_o !== 1'b1) begin n_fail++; $display("FAIL sub2_zero got %b want 1", zero_o); end
        n_cmp++; if (neg_o !== 1'b0) begin n_fail++; $display("FAIL sub2_neg got %b want 0", neg_o); end
`endif
        release_result();
    endtask

    task automatic test_backpressure();
        int e;
        // 0xA7 + 0x6B + 0 = 0x112 -> sum 0x12, carry 1
        start_op(8'hA7, 8'h6B, 1'b0, 1'b0);
        wait_valid(e);
        n_cmp++; if (sum_o !== 8'h12) begin n_fail++; $display("FAIL bp_sum got %h want 12", sum_o); end
        n_cmp++; if (carry_o !== 1'b1) begin n_fail++; $display("FAIL bp_carry got %b want 1", carry_o); end
        for (int i = 0; i < 5; i++) begin
            a_i = 8'h01 + 8'(i); b_i = 8'h01; sub_i = 1'b0; carry_i = 1'b0; valid_i = 1'b1;
            @(posedge clk); #1;
            valid_i = 1'b0;
            n_cmp++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %b want 1", i, valid_o); end
            n_cmp++; if (sum_o !== 8'h12) begin n_fail++; $display("FAIL bp_sum[%0d] got %h want 12", i, sum_o); end
            n_cmp++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d] got %b want 0", i, ready_o); end
        end
        release_result();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_no_queue got %b want 0", valid_o); end
        n_cmp++; if (sum_o !== 8'h12) begin n_fail++; $display("FAIL bp_sum_kept got %h want 12", sum_o); end
    endtask

    task automatic test_reset_mid_run();
        start_op(8'h3C, 8'h58, 1'b0, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_cmp++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_run_ready got %b want 1", ready_o); end
        n_cmp++; if (sum_o !== 8'h00) begin n_fail++; $display("FAIL rst_run_sum got %h want 00", sum_o); end
        n_cmp++; if (carry_o !== 1'b0) begin n_fail++; $display("FAIL rst_run_carry got %b want 0", carry_o); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_run_valid[%0d] got %b want 0", i, valid_o); end
        end
    endtask

    task automatic test_single_chunk();
        int e;
        a_i1 = 8'hFF; b_i1 = 8'h01; sub_i1 = 1'b0; carry_i1 = 1'b0; valid_i1 = 1'b1;
        @(posedge clk); #1;
        valid_i1 = 1'b0;
        e = 0;
        while (!valid_o1 && e < 20) begin
            @(posedge clk); #1;
            e++;
        end
        n_cmp++; if (e !== 1) begin n_fail++; $display("FAIL one_latency got %0d want 1", e); end
        n_cmp++; if (sum_o1 !== 8'h00) begin n_fail++; $display("FAIL one_sum got %h want 00", sum_o1); end
        n_cmp++; if (carry_o1 !== 1'b1) begin n_fail++; $display("FAIL one_carry got %b want 1", carry_o1); end
`ifdef FLAGS_EN
        n_cmp++; if (zero_o1 !== 1'b1) begin n_fail++; $display("FAIL one_zero got %b want 1", zero_o1); end
`endif
        ready_i1 = 1'b1;
        @(posedge clk); #1;
        ready_i1 = 1'b0;
        n_cmp++; if (ready_o1 !== 1'b1) begin n_fail++; $display("FAIL one_ready_after got %b want 1", ready_o1); end
    endtask

    initial begin
        rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b0; a_i = '0; b_i = '0; sub_i = 1'b0;
        carry_i = 1'b0; valid_i1 = 1'b0; ready_i1 = 1'b0; a_i1 = '0; b_i1 = '0;
        sub_i1 = 1'b0; carry_i1 = 1'b0;
        @(negedge clk);
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_reset_mid_run();
        test_single_chunk();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
